fnd_scan_controller: RTL and testbench
======================================

# fnd_scan_controller

Time-multiplexed scan controller for a 4-digit common-anode FND. Holds a double-buffered 4-digit BCD frame, sequences digit enables with a dead-time interval between digits, and drives active-low segment fonts through a BCD-to-segment decoder sub-module. Sits between the timer/MCU-facing logic that produces BCD values and the FND pins, and owns all display timing.

## Interface
- ON_CYCLES, 99_000: clocks each digit is lit per slot; must be ≥ 1.
- BLANK_CYCLES, 1_000: dead-time clocks before each digit, with all selects off; must be ≥ 1.
- i_clk  in  1  system clock; single clock domain.
- i_reset  in  1  reset, synchronous and active-high.
- i_value  in  16  four BCD nibbles; digit0 = [3:0] … digit3 = [15:12].
- i_dp  in  4  decimal-point request per digit, 1 = lit.
- i_blank  in  4  per-digit blank request, 1 = dark.
- i_load  in  1  1-cycle strobe; capture i_value/i_dp/i_blank into staging.
- o_load_pending  out  1  staging holds data not yet committed to display.
- o_frame_done  out  1  1-cycle pulse at each frame boundary.
- o_fndSelect  out  4  digit enables, active-low one-hot or 4'hF.
- o_font  out  8  segments {dp,g,f,e,d,c,b,a}, active-low.

## Operation
- FSM states: ST_BLANK, ST_ON. Slot counter `cnt` and digit index `dig` (2 bits).
- ST_BLANK: o_fndSelect = 4'hF, o_font = 8'hFF for BLANK_CYCLES clocks, then ST_ON with the same `dig`.
- ST_ON: o_fndSelect = ~(4'b1 << dig), o_font = font(dig) for ON_CYCLES clocks. The FSM then moves to ST_BLANK with `dig`+1, wrapping 3 → 0.
- Frame boundary is the ST_ON(dig=3) → ST_BLANK(dig=0) transition. On that edge:
  - o_frame_done pulses.
  - Staging is copied to the shadow registers if o_load_pending is set.
  - o_load_pending clears.
- i_load sets o_load_pending and overwrites staging; the latest load wins.
- i_load on the boundary cycle commits that cycle's inputs directly; pending stays 0.
- The displayed frame never changes mid-frame (no tearing).
- font(d) rules:
  - If shadow blank[d] is set: 8'hFF, with dp suppressed.
  - Otherwise: decoder(nibble) with bit7 cleared when dp[d] is set.
- Decoder map:
  - 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90.
  - A → 7F (dot only).
  - B–F → FF.
- Reset values:
  - State ST_BLANK, dig 0, cnt 0.
  - Shadow value 0, dp 0, blank 4'hF (display dark until first commit).
  - Staging 0, o_load_pending 0, o_frame_done 0, o_fndSelect 4'hF, o_font 8'hFF.
- Reset mid-slot: next cycle all outputs at reset values, and pending data is discarded.

## Timing
- All outputs are registered and change on the same edge as the state/digit change. No combinational path from inputs to outputs.
- Slot = BLANK_CYCLES + ON_CYCLES clocks. Frame = 4 × slot.
- After reset release, the first boundary is at clock 4 × slot.
- Commit latency: load to displayed is at most 1 frame + BLANK_CYCLES clocks.
- At no cycle is more than one o_fndSelect bit low.
- `cnt` width is $clog2(max(ON_CYCLES, BLANK_CYCLES)). The counter resets to 0 on every state transition.

## Configuration
- FND_LZB_EN defined: leading-zero blanking on the shadow frame.
  - Digit d ∈ {3,2,1} is forced dark (FF) when its nibble and all higher nibbles are 0 and none of those digits has dp set.
  - Digit0 is never auto-blanked.
- FND_LZB_EN undefined: zeros display as C0 everywhere; only i_blank darkens digits.

## Structure
- Package fnd_pkg holds:
  - State enum (ST_BLANK, ST_ON).
  - Font constants FONT_0..FONT_9, FONT_DOT = 8'h7F, FONT_OFF = 8'hFF.
  - SEL_OFF = 4'hF.
  - NUM_DIGITS = 4.
- Sub-module fnd_font_decoder: combinational 4-bit → 8-bit font map per Operation.
- Instantiated once in fnd_scan_controller, muxed by `dig`.

## Test plan
All tests use ON_CYCLES=4, BLANK_CYCLES=2 (slot 6, frame 24).
- Reset and first frame:
  - Stimulus: release reset; i_load with 16'h1234, dp 0, blank 0 at clk 3.
  - Frame 0: all dark.
  - o_frame_done and commit at clk 24.
  - Frame 1 ON slots show digit0 99, digit1 B0, digit2 A4, digit3 F9 with selects E, D, B, 7.
  - o_fndSelect = F for exactly 2 cycles before each digit.
- dp and blank:
  - Stimulus: value 16'h0A57, dp 4'b0010, blank 4'b1000.
  - Expected fonts: digit0 F8, digit1 12, digit2 7F, digit3 FF.
- Anti-tearing:
  - Stimulus: load 16'h1111 at clk 30, then 16'h2222 at clk 40.
  - o_load_pending is high from clk 31 until the boundary at clk 48.
  - Frame through clk 47 is unchanged.
  - Next frame shows all A4.
- Load on the boundary cycle: 16'h9999 committed at that edge; o_load_pending never asserts.
- Reset asserted mid-ST_ON for digit2: next cycle select F, font FF, pending 0, and the display stays dark until the next commit.
- Leading-zero blanking, value 16'h0050:
  - With FND_LZB_EN: digits 3,2 FF; digit1 92; digit0 C0.
  - Without FND_LZB_EN: C0, C0, 92, C0.

Source files
------------

// File: rtl/fnd_pkg.sv
// Shared types and constants for the FND scan controller and its font decoder.
package fnd_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } state_t;

  localparam int NUM_DIGITS = 4;

  localparam logic [3:0] SEL_OFF = 4'hF;

  // Active-low segment fonts, bit order {dp,g,f,e,d,c,b,a}
  localparam logic [7:0] FONT_0   = 8'hC0;
  localparam logic [7:0] FONT_1   = 8'hF9;
  localparam logic [7:0] FONT_2   = 8'hA4;
  localparam logic [7:0] FONT_3   = 8'hB0;
  localparam logic [7:0] FONT_4   = 8'h99;
  localparam logic [7:0] FONT_5   = 8'h92;
  localparam logic [7:0] FONT_6   = 8'h82;
  localparam logic [7:0] FONT_7   = 8'hF8;
  localparam logic [7:0] FONT_8   = 8'h80;
  localparam logic [7:0] FONT_9   = 8'h90;
  localparam logic [7:0] FONT_DOT = 8'h7F;
  localparam logic [7:0] FONT_OFF = 8'hFF;

  // A slot counter of at least one bit wide enough for the longer phase
  function automatic int cnt_width(input int on_cycles, input int blank_cycles);
    int longest;
    longest = (on_cycles > blank_cycles) ? on_cycles : blank_cycles;
    return ($clog2(longest) < 1) ? 1 : $clog2(longest);
  endfunction

endpackage

// File: rtl/fnd_font_decoder.sv
// Combinational BCD nibble to active-low seven-segment font map.
module fnd_font_decoder
  import fnd_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] font
);

  always_comb begin
    font = FONT_OFF;
    case (nibble)
      4'h0: font = FONT_0;
      4'h1: font = FONT_1;
      4'h2: font = FONT_2;
      4'h3: font = FONT_3;
      4'h4: font = FONT_4;
      4'h5: font = FONT_5;
      4'h6: font = FONT_6;
      4'h7: font = FONT_7;
      4'h8: font = FONT_8;
      4'h9: font = FONT_9;
      4'hA: font = FONT_DOT;
      default: font = FONT_OFF;
    endcase
  end

endmodule

// File: rtl/fnd_scan_controller.sv
// Four-digit common-anode FND scanner with double-buffered frame and dead-time between digits.
// Optional leading-zero blanking is enabled by defining FND_LZB_EN.
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int ON_CYCLES    = 99_000,
  parameter int BLANK_CYCLES = 1_000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_value,
  input  logic [3:0]  i_dp,
  input  logic [3:0]  i_blank,
  input  logic        i_load,
  output logic        o_load_pending,
  output logic        o_frame_done,
  output logic [3:0]  o_fndSelect,
  output logic [7:0]  o_font
);

  localparam int CW = cnt_width(ON_CYCLES, BLANK_CYCLES);
  localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  state_t      state;
  logic [CW-1:0] cnt;
  logic [1:0]  dig;

  logic [15:0] stage_value, shadow_value;
  logic [3:0]  stage_dp, shadow_dp;
  logic [3:0]  stage_blank, shadow_blank;

  logic [3:0]  cur_nibble;
  logic [7:0]  dec_font;
  logic        lead_zero;
  logic [7:0]  font_next;
  logic        boundary;

  assign cur_nibble = shadow_value[{dig, 2'b00} +: 4];

  fnd_font_decoder u_decoder (
    .nibble (cur_nibble),
    .font   (dec_font)
  );

`ifdef FND_LZB_EN
  // A digit goes dark when it and every higher digit are zero with no dp lit
  assign lead_zero = (dig != 2'd0) &&
                     ((shadow_value >> {dig, 2'b00}) == 16'd0) &&
                     ((shadow_dp >> dig) == 4'd0);
`else
  assign lead_zero = 1'b0;
`endif

  assign font_next = (shadow_blank[dig] || lead_zero) ? FONT_OFF :
                     (shadow_dp[dig] ? (dec_font & 8'h7F) : dec_font);

  assign boundary = (state == ST_ON) && (cnt == ON_LAST) && (dig == 2'd3);

  // The shadow frame only changes on the frame boundary, so a frame is never torn
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state          <= ST_BLANK;
      cnt            <= '0;
      dig            <= 2'd0;
      stage_value    <= 16'd0;
      stage_dp       <= 4'd0;
      stage_blank    <= 4'd0;
      shadow_value   <= 16'd0;
      shadow_dp      <= 4'd0;
      shadow_blank   <= 4'hF;
      o_load_pending <= 1'b0;
      o_frame_done   <= 1'b0;
      o_fndSelect    <= SEL_OFF;
      o_font         <= FONT_OFF;
    end else begin
      o_frame_done <= 1'b0;

      if (boundary) begin
        o_frame_done   <= 1'b1;
        o_load_pending <= 1'b0;
        if (i_load) begin
          stage_value  <= i_value;
          stage_dp     <= i_dp;
          stage_blank  <= i_blank;
          shadow_value <= i_value;
          shadow_dp    <= i_dp;
          shadow_blank <= i_blank;
        end else if (o_load_pending) begin
          shadow_value <= stage_value;
          shadow_dp    <= stage_dp;
          shadow_blank <= stage_blank;
        end
      end else if (i_load) begin
        stage_value    <= i_value;
        stage_dp       <= i_dp;
        stage_blank    <= i_blank;
        o_load_pending <= 1'b1;
      end

      case (state)
        ST_BLANK: begin
          if (cnt == BLANK_LAST) begin
            state       <= ST_ON;
            cnt         <= '0;
            o_fndSelect <= ~(4'b0001 << dig);
            o_font      <= font_next;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_ON: begin
          if (cnt == ON_LAST) begin
            state       <= ST_BLANK;
            cnt         <= '0;
            dig         <= dig + 2'd1;
            o_fndSelect <= SEL_OFF;
            o_font      <= FONT_OFF;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_BLANK;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Self-checking bench for fnd_scan_controller: cycle scoreboard plus table-driven frame vectors.
module tb_fnd_scan_controller;

  localparam int ON_C    = 4;
  localparam int BLANK_C = 2;
  localparam int SLOT    = ON_C + BLANK_C;
  localparam int FRAME   = 4 * SLOT;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = 16'd0;
  logic [3:0]  dp = 4'd0;
  logic [3:0]  blank = 4'd0;
  logic        load = 1'b0;
  logic        load_pending;
  logic        frame_done;
  logic [3:0]  fnd_select;
  logic [7:0]  font;

  always #5 clk = ~clk;

  fnd_scan_controller #(
    .ON_CYCLES    (ON_C),
    .BLANK_CYCLES (BLANK_C)
  ) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_value        (value),
    .i_dp           (dp),
    .i_blank        (blank),
    .i_load         (load),
    .o_load_pending (load_pending),
    .o_frame_done   (frame_done),
    .o_fndSelect    (fnd_select),
    .o_font         (font)
  );

  typedef struct packed {
    logic [3:0] sel;
    logic [7:0] font;
    logic       fd;
    logic       pend;
  } exp_t;

  typedef struct packed {
    logic [15:0]     v;
    logic [3:0]      d;
    logic [3:0]      b;
    logic [3:0][7:0] f;
  } vec_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;

  // Reference model tracks position within the frame rather than an FSM
  int          m_pos = 0;
  logic [15:0] m_sh_val = 16'd0, m_st_val = 16'd0;
  logic [3:0]  m_sh_dp = 4'd0, m_st_dp = 4'd0;
  logic [3:0]  m_sh_bl = 4'hF, m_st_bl = 4'd0;
  logic        m_pend = 1'b0, m_fd = 1'b0;
  logic [7:0]  cap [4];

  function automatic logic [7:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0;
      4'h1: return 8'hF9;
      4'h2: return 8'hA4;
      4'h3: return 8'hB0;
      4'h4: return 8'h99;
      4'h5: return 8'h92;
      4'h6: return 8'h82;
      4'h7: return 8'hF8;
      4'h8: return 8'h80;
      4'h9: return 8'h90;
      4'hA: return 8'h7F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [7:0] model_font(input int d);
    logic       lz;
    logic [3:0] n;
    lz = 1'b0;
`ifdef FND_LZB_EN
    if (d > 0) begin
      lz = 1'b1;
      for (int k = d; k < 4; k++)
        if (m_sh_val[k*4 +: 4] != 4'd0 || m_sh_dp[k]) lz = 1'b0;
    end
`endif
    n = m_sh_val[d*4 +: 4];
    if (m_sh_bl[d] || lz) return 8'hFF;
    return m_sh_dp[d] ? (seg_of(n) & 8'h7F) : seg_of(n);
  endfunction

  task automatic checkOutput();
    exp_t       e;
    logic [3:0] oh;
    checks++;
    if (sb_q.size() == 0) begin
      $display("[TB] FAIL scoreboard_empty got no expectation want one at t=%0t", $time);
      return;
    end
    e = sb_q.pop_front();
    if ({fnd_select, font, frame_done, load_pending} === e) passes++;
    else
      $display("[TB] FAIL cycle_outputs t=%0t got sel=%h font=%h fd=%b pend=%b want sel=%h font=%h fd=%b pend=%b",
               $time, fnd_select, font, frame_done, load_pending, e.sel, e.font, e.fd, e.pend);
    for (int d = 0; d < 4; d++) begin
      oh = 4'b0001 << d;
      if (fnd_select === ~oh) cap[d] = font;
    end
  endtask

  // Advance the model by one clock with the current inputs, queue the expectation, clock the DUT
  task automatic applyStimulus();
    exp_t e;
    int   slot, r;
    if (reset) begin
      m_pos = 0; m_pend = 1'b0; m_fd = 1'b0;
      m_sh_val = 16'd0; m_sh_dp = 4'd0; m_sh_bl = 4'hF;
      m_st_val = 16'd0; m_st_dp = 4'd0; m_st_bl = 4'd0;
      cyc = 0;
    end else begin
      if (m_pos == FRAME - 1) begin
        m_fd = 1'b1;
        if (load) begin
          m_sh_val = value; m_sh_dp = dp; m_sh_bl = blank;
        end else if (m_pend) begin
          m_sh_val = m_st_val; m_sh_dp = m_st_dp; m_sh_bl = m_st_bl;
        end
        m_pend = 1'b0;
      end else begin
        m_fd = 1'b0;
        if (load) begin
          m_st_val = value; m_st_dp = dp; m_st_bl = blank; m_pend = 1'b1;
        end
      end
      m_pos = (m_pos + 1) % FRAME;
      cyc++;
    end
    slot = m_pos / SLOT;
    r    = m_pos % SLOT;
    if (r < BLANK_C) begin
      e.sel  = 4'hF;
      e.font = 8'hFF;
    end else begin
      e.sel  = ~(4'b0001 << slot);
      e.font = model_font(slot);
    end
    e.fd   = m_fd;
    e.pend = m_pend;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic check_val(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got === want) passes++;
    else $display("[TB] FAIL %s got %h want %h", name, got, want);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic wait_frame_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < FRAME + 2 && !seen; i++) begin
      applyStimulus();
      if (frame_done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) passes++;
    else $display("[TB] FAIL frame_done_wait got no pulse want one within %0d cycles", FRAME + 2);
  endtask

  task automatic goto_pos(input int p);
    for (int i = 0; i < FRAME && m_pos != p; i++) applyStimulus();
  endtask

  task automatic load_frame(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    value = v; dp = d; blank = b; load = 1'b1;
    applyStimulus();
    load = 1'b0;
  endtask

  task automatic clear_cap();
    for (int d = 0; d < 4; d++) cap[d] = 8'hxx;
  endtask

  task automatic check_cap(input string name, input logic [3:0][7:0] f);
    for (int d = 0; d < 4; d++) check_val($sformatf("%s_digit%0d", name, d), cap[d], f[d]);
  endtask

  vec_t vecs [7];

  initial begin
    vecs[0] = '{v: 16'h1234, d: 4'b0000, b: 4'b0000, f: {8'hF9, 8'hA4, 8'hB0, 8'h99}};
    vecs[1] = '{v: 16'h0A57, d: 4'b0010, b: 4'b1000, f: {8'hFF, 8'h7F, 8'h12, 8'hF8}};
    vecs[2] = '{v: 16'h8760, d: 4'b0001, b: 4'b0000, f: {8'h80, 8'hF8, 8'h82, 8'h40}};
    vecs[3] = '{v: 16'hBCDE, d: 4'b1111, b: 4'b0000, f: {8'h7F, 8'h7F, 8'h7F, 8'h7F}};
    vecs[4] = '{v: 16'h1003, d: 4'b0001, b: 4'b0001, f: {8'hF9, 8'hC0, 8'hC0, 8'hFF}};
`ifdef FND_LZB_EN
    vecs[5] = '{v: 16'h0050, d: 4'b0000, b: 4'b0000, f: {8'hFF, 8'hFF, 8'h92, 8'hC0}};
    vecs[6] = '{v: 16'h0000, d: 4'b0100, b: 4'b0000, f: {8'hFF, 8'h40, 8'hC0, 8'hC0}};
`else
    vecs[5] = '{v: 16'h0050, d: 4'b0000, b: 4'b0000, f: {8'hC0, 8'hC0, 8'h92, 8'hC0}};
    vecs[6] = '{v: 16'h0000, d: 4'b0100, b: 4'b0000, f: {8'hC0, 8'h40, 8'hC0, 8'hC0}};
`endif

    reset = 1'b1;
    run(2);
    check_val("reset_select", {4'h0, fnd_select}, 8'h0F);
    check_val("reset_font", font, 8'hFF);
    check_val("reset_pending", {7'd0, load_pending}, 8'h00);
    reset = 1'b0;

    // First frame stays dark, the load commits on the first boundary
    clear_cap();
    run(3);
    load_frame(16'h1234, 4'b0000, 4'b0000);
    check_val("pending_after_load", {7'd0, load_pending}, 8'h01);
    wait_frame_done();
    check_val("first_boundary_cycle", 8'(cyc), 8'(FRAME));
    check_cap("frame0_dark", {8'hFF, 8'hFF, 8'hFF, 8'hFF});
    clear_cap();
    run(FRAME - 1);
    check_cap("frame1_1234", vecs[0].f);

    for (int i = 0; i < 7; i++) begin
      run(4);
      load_frame(vecs[i].v, vecs[i].d, vecs[i].b);
      wait_frame_done();
      clear_cap();
      run(FRAME - 1);
      check_cap($sformatf("vec%0d", i), vecs[i].f);
    end

    // Two loads inside one frame: display holds, latest load wins at the boundary
    applyStimulus();
    clear_cap();
    run(5);
    load_frame(16'h1111, 4'b0000, 4'b0000);
    run(9);
    load_frame(16'h2222, 4'b0000, 4'b0000);
    check_val("pending_before_boundary", {7'd0, load_pending}, 8'h01);
    wait_frame_done();
    check_cap("no_tearing", vecs[6].f);
    check_val("pending_after_commit", {7'd0, load_pending}, 8'h00);
    clear_cap();
    run(FRAME - 1);
    check_cap("latest_load", {8'hA4, 8'hA4, 8'hA4, 8'hA4});

    goto_pos(FRAME - 1);
    load_frame(16'h9999, 4'b0000, 4'b0000);
    check_val("boundary_load_fd", {7'd0, frame_done}, 8'h01);
    check_val("boundary_load_pending", {7'd0, load_pending}, 8'h00);
    clear_cap();
    run(FRAME - 1);
    check_cap("boundary_load", {8'h90, 8'h90, 8'h90, 8'h90});

    // Reset during digit2 ON with a load pending discards everything
    goto_pos(2 * SLOT + BLANK_C + 1);
    load_frame(16'h4321, 4'b0000, 4'b0000);
    reset = 1'b1;
    applyStimulus();
    reset = 1'b0;
    check_val("midreset_select", {4'h0, fnd_select}, 8'h0F);
    check_val("midreset_font", font, 8'hFF);
    check_val("midreset_pending", {7'd0, load_pending}, 8'h00);
    clear_cap();
    run(FRAME - 1);
    check_cap("after_reset_f0", {8'hFF, 8'hFF, 8'hFF, 8'hFF});
    wait_frame_done();
    clear_cap();
    run(FRAME - 1);
    check_cap("after_reset_f1", {8'hFF, 8'hFF, 8'hFF, 8'hFF});

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
